// File: rtl/imem_loader_if.sv
// Signal bundle between the boot/debug byte source, the loader and the
// instruction memory write port.
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W:0]   len;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              core_hold;
   logic              busy;
   logic              done;
   logic [31:0]       checksum;

   // Byte stream: a byte moves on a rising edge where in_valid and in_ready
   // are both high; in_ready never depends on in_valid, and the source may
   // drop in_valid at any time without penalty.
   modport master (
      output start, len, in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data, core_hold, busy, done, checksum
   );

   modport slave (
      input  start, len, in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data, core_hold, busy, done, checksum
   );
endinterface

// File: rtl/imem_loader.sv
// Assembles little-endian 32-bit words from a byte stream and writes them to
// instruction memory from word 0 while holding the core off.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_loader_if.slave         bus,
   output logic [1:0]           state_dbg
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state;
   logic [ADDR_W:0]   eff_len;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   cnt_inc;
   logic [1:0]        byte_cnt;
   logic [23:0]       word_buf;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [31:0]       sum_q;

   assign cnt_inc = word_cnt + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         eff_len  <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         word_buf <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         sum_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  eff_len  <= (bus.len > DEPTH) ? DEPTH : bus.len;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  sum_q    <= '0;
                  state    <= (bus.len == '0) ? S_DONE : S_RECV;
               end
            end
            S_RECV: begin
               if (bus.in_valid) begin
                  if (byte_cnt == 2'd3) begin
                     // Fourth byte completes the word; the write registers
                     // keep it stable through WRITE and afterwards.
                     data_q   <= {bus.in_data, word_buf};
                     addr_q   <= word_cnt[ADDR_W-1:0];
                     byte_cnt <= 2'd0;
                     state    <= S_WRITE;
                  end else begin
                     word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               sum_q    <= sum_q + data_q;
               word_cnt <= cnt_inc;
               state    <= (cnt_inc == eff_len) ? S_DONE : S_RECV;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_RECV);
   assign bus.wr_en     = (state == S_WRITE);
   assign bus.wr_addr   = addr_q;
   assign bus.wr_data   = data_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.core_hold = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.checksum  = sum_q;
   assign state_dbg     = state;
endmodule
